// File: rtl/mult_pkg.sv
// Shared types for the add-shift multiplier sequencer.
package mult_pkg;

    localparam int N_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR_XA,
        ADDSUB,
        SHIFT,
        DONE
    } mult_state_t;

endpackage

// File: rtl/run_edge_sync.sv
// Two-flop synchroniser for the Run button plus rising-edge detect.
module run_edge_sync (
    input  logic Clk,
    input  logic Reset_Load_Clear,
    input  logic async_in,
    output logic level_out,
    output logic rise_out
);

    logic       run_meta;
    logic       run_sync;
    logic       run_prev;
    logic       armed;
    logic [1:0] fill;

    // armed only once the pipe holds a real low sample, so a
    // button held through reset release never looks like an edge
    always_ff @(posedge Clk or negedge Reset_Load_Clear) begin
        if (!Reset_Load_Clear) begin
            run_meta <= 1'b0;
            run_sync <= 1'b0;
            run_prev <= 1'b0;
            armed    <= 1'b0;
            fill     <= 2'b00;
        end else begin
            run_meta <= async_in;
            run_sync <= run_meta;
            run_prev <= run_sync;
            fill     <= {fill[0], 1'b1};
            if (fill[1] && !run_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign level_out = run_sync;
    assign rise_out  = run_sync & ~run_prev & armed;

endmodule

// File: rtl/mult_ctrl_unit.sv
// Sequencer turning Run/Load buttons into one-cycle datapath strobes
// for the signed add-shift multiplier.
module mult_ctrl_unit
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CNT_W  = $clog2(N_BITS + 1)
) (
    input  logic Clk,
    input  logic Reset_Load_Clear,
    input  logic Run,
    input  logic Load,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Done,
    output logic Busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(N_BITS);

    mult_state_t      state;
    mult_state_t      state_nx;
    logic [CNT_W-1:0] count;
    logic             run_level;
    logic             start;

    run_edge_sync u_run (
        .Clk              (Clk),
        .Reset_Load_Clear (Reset_Load_Clear),
        .async_in         (Run),
        .level_out        (run_level),
        .rise_out         (start)
    );

    always_ff @(posedge Clk or negedge Reset_Load_Clear) begin
        if (!Reset_Load_Clear) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            if (state == CLR_XA) begin
                count <= '0;
            end else if (state == SHIFT && count != CMAX) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        Clr_Ld   = 1'b0;
        Clr_XA   = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift    = 1'b0;
        Done     = 1'b0;
        Busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Load) begin
                    state_nx = LOAD;
                end else if (start) begin
                    state_nx = CLR_XA;
                end
            end
            LOAD: begin
                Clr_Ld   = 1'b1;
                state_nx = IDLE;
            end
            CLR_XA: begin
                Clr_XA   = 1'b1;
                Busy     = 1'b1;
                state_nx = ADDSUB;
            end
            ADDSUB: begin
                Busy = 1'b1;
                // final iteration weighs the sign bit negatively
                if (count < LAST) begin
                    Add = M;
                end else if (count == LAST) begin
                    Sub = M;
                end
                state_nx = SHIFT;
            end
            SHIFT: begin
                Shift    = 1'b1;
                Busy     = 1'b1;
                state_nx = (count == LAST) ? DONE : ADDSUB;
            end
            DONE: begin
                Done = 1'b1;
                if (!run_level) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_ctrl_unit.sv
// Bench for mult_ctrl_unit: behavioural X|A|B datapath closes the M loop.
module tb_mult_ctrl_unit;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_LD   = 7'b1000000;
    localparam logic [6:0] S_CX   = 7'b0100001;
    localparam logic [6:0] S_ADD  = 7'b0010001;
    localparam logic [6:0] S_SUB  = 7'b0001001;
    localparam logic [6:0] S_SH   = 7'b0000101;
    localparam logic [6:0] S_DN   = 7'b0000010;
    localparam logic [6:0] S_BUSY = 7'b0000001;

    logic Clk = 1'b0;
    logic Reset_Load_Clear;
    logic Run;
    logic Load;
    logic M;
    logic Clr_Ld, Clr_XA, Add, Sub, Shift, Done, Busy;

    logic [7:0] sw = 8'h00;
    logic       x = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    int errors = 0;
    int checks = 0;

    wire [6:0] obs = {Clr_Ld, Clr_XA, Add, Sub, Shift, Done, Busy};

    always #5 Clk = ~Clk;

    assign M = b[0];

    mult_ctrl_unit dut (
        .Clk              (Clk),
        .Reset_Load_Clear (Reset_Load_Clear),
        .Run              (Run),
        .Load             (Load),
        .M                (M),
        .Clr_Ld           (Clr_Ld),
        .Clr_XA           (Clr_XA),
        .Add              (Add),
        .Sub              (Sub),
        .Shift            (Shift),
        .Done             (Done),
        .Busy             (Busy)
    );

    always @(posedge Clk) begin
        if (Clr_Ld) begin
            x <= 1'b0;
            a <= 8'h00;
            b <= sw;
        end else if (Clr_XA) begin
            {x, a} <= 9'h000;
        end else if (Add) begin
            {x, a} <= {x, a} + {sw[7], sw};
        end else if (Sub) begin
            {x, a} <= {x, a} - {sw[7], sw};
        end else if (Shift) begin
            {x, a, b} <= {x, x, a, b[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] e);
        @(negedge Clk);
        check(tag, {25'd0, obs}, {25'd0, e});
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        sw   = v;
        Load = 1'b1;
        step("ld_req", S_NONE);
        Load = 1'b0;
        step("ld_pulse", S_LD);
        step("ld_idle", S_NONE);
        check("ld_b", {24'd0, b}, {24'd0, v});
    endtask

    task automatic do_run(input logic [7:0] bv, input logic [7:0] swv,
                          input bit ld_busy);
        logic [15:0] prod;
        logic [6:0]  e;
        prod = 16'($signed({{8{bv[7]}}, bv}) * $signed({{8{swv[7]}}, swv}));
        sw  = swv;
        Run = 1'b1;
        step("sync0", S_NONE);
        step("sync1", S_NONE);
        step("start", S_NONE);
        if (ld_busy) Load = 1'b1;
        step("clr_xa", S_CX);
        for (int i = 0; i < 8; i++) begin
            if (!bv[i]) e = S_BUSY;
            else e = (i == 7) ? S_SUB : S_ADD;
            step("addsub", e);
            step("shift", S_SH);
        end
        Load = 1'b0;
        step("done", S_DN);
        check("product", {16'd0, a, b}, {16'd0, prod});
        repeat (3) step("hold_done", S_DN);
        Run = 1'b0;
        repeat (3) step("release", S_DN);
        step("back_idle", S_NONE);
        repeat (2) step("idle", S_NONE);
    endtask

    initial begin
        Reset_Load_Clear = 1'b0;
        Run  = 1'b0;
        Load = 1'b0;
        #3;
        check("reset_outs", {25'd0, obs}, 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_Load_Clear = 1'b1;
        repeat (4) step("post_reset", S_NONE);

        do_load(8'h07);
        do_run(8'h07, 8'h05, 1'b0);

        do_load(8'h80);
        do_run(8'h80, 8'h03, 1'b0);
        do_run(8'h80, 8'h03, 1'b0);

        for (int k = 0; k < 3; k++) begin
            logic [7:0] rb;
            logic [7:0] rs;
            rb = 8'($urandom);
            rs = 8'($urandom);
            do_load(rb);
            do_run(rb, rs, k == 1);
        end

        do_load(8'hff);
        sw  = 8'h11;
        Run = 1'b1;
        step("r_sync0", S_NONE);
        step("r_sync1", S_NONE);
        step("r_start", S_NONE);
        step("r_clr", S_CX);
        for (int i = 0; i < 4; i++) begin
            step("r_addsub", S_ADD);
            step("r_shift", S_SH);
        end
        #2;
        check("pre_reset", {25'd0, obs}, {25'd0, S_ADD});
        Reset_Load_Clear = 1'b0;
        #1;
        check("rst_async", {25'd0, obs}, 32'd0);
        @(posedge Clk);
        #1;
        step("rst_hold", S_NONE);
        Reset_Load_Clear = 1'b1;
        repeat (8) step("no_start", S_NONE);
        Run = 1'b0;
        repeat (4) step("idle", S_NONE);
        do_load(8'h5a);
        do_run(8'h5a, 8'hc3, 1'b0);

        do_load(8'h33);
        Run = 1'b1;
        step("lr_sync0", S_NONE);
        step("lr_sync1", S_NONE);
        Load = 1'b1;
        step("ld_vs_run", S_NONE);
        Load = 1'b0;
        step("ld_wins", S_LD);
        repeat (6) step("run_lost", S_NONE);
        Run = 1'b0;
        repeat (4) step("idle", S_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
